// File: rtl/sram_sp_arbiter_if.sv
// Requester-side bundle for sram_sp_arbiter: request handshake plus read-return strobe.
// Latency: none (wires only); rsp_* lags the accepted read by two cycles.
// Backpressure: req_ready throttles requests; responses have no backpressure.
//
// Signals:
//   req_valid/req_ready/req_wen  per-requester handshake and direction (1 = write)
//   req_addr/req_wdata           flattened per-requester fields, requester i at [i*W +: W]
//   rsp_valid                    one-hot read-return strobe
//   rsp_rdata/rsp_id             returned word and the id of the requester that issued it
// master = requester logic, slave = arbiter.
interface sram_sp_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_BIT = 128,
  parameter int ADDR_BIT = 9,
  parameter int ID_BIT   = 2
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          req_wen;
  logic [NUM_REQ*ADDR_BIT-1:0] req_addr;
  logic [NUM_REQ*DATA_BIT-1:0] req_wdata;
  logic [NUM_REQ-1:0]          rsp_valid;
  logic [DATA_BIT-1:0]         rsp_rdata;
  logic [ID_BIT-1:0]           rsp_id;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_id
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_id
  );
endinterface

// File: rtl/sram_sp_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM between NUM_REQ requesters.
// Latency: grant and SRAM pins are combinational; read data returns 2 cycles after grant.
// Backpressure: one grant per cycle via req_ready; responses cannot be stalled.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_if         slave side of sram_sp_arbiter_if (requests in, responses out)
//   sram_addr/wen/ren/wdata  driven to the SRAM from the granted requester
//   sram_rdata     SRAM read data (valid 2 cycles after sram_ren)
//   busy           high while any read is in flight
// Optional feature: define SRAM_ARB_PRIO0_EN to give requester 0 fixed top priority,
// with requesters 1..NUM_REQ-1 round-robin among themselves.
module sram_sp_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_BIT = 128,
  parameter int DEPTH    = 512,
  parameter int ADDR_BIT = $clog2(DEPTH),
  parameter int ID_BIT   = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_sp_arbiter_if.slave     req_if,
  output logic [ADDR_BIT-1:0]  sram_addr,
  output logic                 sram_wen,
  output logic                 sram_ren,
  output logic [DATA_BIT-1:0]  sram_wdata,
  input  logic [DATA_BIT-1:0]  sram_rdata,
  output logic                 busy
);

  // One in-flight read tag per SRAM pipeline stage.
  typedef struct packed {
    logic              vld;
    logic [ID_BIT-1:0] id;
  } tag_t;

  localparam logic [ID_BIT:0] NUM_REQ_W = (ID_BIT+1)'(NUM_REQ);

  logic [ID_BIT-1:0] rr_ptr_q, rr_ptr_d;
  tag_t              stage0_q, stage0_d;
  tag_t              stage1_q, stage1_d;

  logic              grant_vld;
  logic [ID_BIT-1:0] grant_id;
  logic [ID_BIT:0]   idx;
  logic [ID_BIT:0]   ptr_nxt;
  logic              ptr_adv;

  // Arbitration: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
`ifdef SRAM_ARB_PRIO0_EN
    // Requester 0 pre-empts the rotation; pre-setting grant_vld disables the search.
    if (req_if.req_valid[0]) begin
      grant_vld = 1'b1;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      // rr_ptr and k are both below NUM_REQ, so one conditional subtract wraps.
      idx = {1'b0, rr_ptr_q} + (ID_BIT+1)'(k);
      if (idx >= NUM_REQ_W) begin
        idx = idx - NUM_REQ_W;
      end
      if (!grant_vld && req_if.req_valid[idx[ID_BIT-1:0]]) begin
        grant_vld = 1'b1;
        grant_id  = idx[ID_BIT-1:0];
      end
    end
  end

  // Pointer moves just past the winner.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    ptr_nxt  = '0;
`ifdef SRAM_ARB_PRIO0_EN
    // Grants to the priority requester leave the rotation untouched.
    ptr_adv  = grant_vld && (grant_id != '0);
`else
    ptr_adv  = grant_vld;
`endif
    if (ptr_adv) begin
      ptr_nxt  = {1'b0, grant_id} + 1'b1;
      rr_ptr_d = (ptr_nxt == NUM_REQ_W) ? '0 : ptr_nxt[ID_BIT-1:0];
    end
  end

  // Grant strobe and SRAM pin drive.
  always_comb begin
    req_if.req_ready = '0;
    sram_addr        = '0;
    sram_wdata       = '0;
    sram_wen         = 1'b0;
    sram_ren         = 1'b0;
    if (grant_vld) begin
      req_if.req_ready[grant_id] = 1'b1;
      sram_addr  = req_if.req_addr[grant_id*ADDR_BIT +: ADDR_BIT];
      sram_wdata = req_if.req_wdata[grant_id*DATA_BIT +: DATA_BIT];
      sram_wen   = req_if.req_wen[grant_id];
      sram_ren   = ~req_if.req_wen[grant_id];
    end
  end

  // Read-tag pipeline mirrors the SRAM's two-cycle read latency.
  always_comb begin
    stage0_d.vld = sram_ren;
    stage0_d.id  = sram_ren ? grant_id : '0;
    stage1_d     = stage0_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      stage0_q <= '0;
      stage1_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      stage0_q <= stage0_d;
      stage1_q <= stage1_d;
    end
  end

  // Responses are masked during reset: a read sitting in stage1 while rst is
  // high is one being discarded, so it must not strobe its requester.
  always_comb begin
    req_if.rsp_valid = '0;
    req_if.rsp_valid[stage1_q.id] = stage1_q.vld & ~rst;
    req_if.rsp_id    = rst ? '0 : stage1_q.id;
    req_if.rsp_rdata = (stage1_q.vld && !rst) ? sram_rdata : '0;
    busy             = (stage0_q.vld | stage1_q.vld) & ~rst;
  end

endmodule

// File: tb/tb_sram_sp_arbiter.sv
// Self-checking bench for sram_sp_arbiter with a behavioural 2-cycle-read SRAM.
// Expected grants are hand-computed per cycle; expected read returns go to a queue
// that an independent monitor drains whenever rsp_valid is seen.
module tb_sram_sp_arbiter;
  localparam int NR = 4;
  localparam int DB = 128;
  localparam int AB = 9;
  localparam int IB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AB-1:0] sram_addr;
  logic          sram_wen, sram_ren;
  logic [DB-1:0] sram_wdata, sram_rdata;
  logic          busy;

  int n_checks = 0;
  int n_err    = 0;
  int cyc_cnt  = 0;

  typedef struct {
    int            id;
    logic [DB-1:0] data;
    int            cyc;
  } rsp_t;
  rsp_t exp_q[$];

  sram_sp_arbiter_if #(.NUM_REQ(NR), .DATA_BIT(DB), .ADDR_BIT(AB), .ID_BIT(IB)) bus ();

  sram_sp_arbiter #(.NUM_REQ(NR), .DATA_BIT(DB), .DEPTH(512)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_if     (bus),
    .sram_addr  (sram_addr),
    .sram_wen   (sram_wen),
    .sram_ren   (sram_ren),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // SRAM model: write on the edge, read data appears two cycles after ren.
  logic [DB-1:0] mem [0:511];
  logic [DB-1:0] p0, p1;
  always @(posedge clk) begin
    if (sram_wen) mem[sram_addr] <= sram_wdata;
    if (sram_ren) p0 <= mem[sram_addr];
    p1 <= p0;
  end
  assign sram_rdata = p1;

  function automatic logic [DB-1:0] pat(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic check(input string nm, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc_cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input bit w,
                         input logic [AB-1:0] a, input logic [DB-1:0] d);
    bus.req_valid[i]            = v;
    bus.req_wen[i]              = w;
    bus.req_addr[i*AB +: AB]    = a;
    bus.req_wdata[i*DB +: DB]   = d;
  endtask

  task automatic clr_all();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, '0, '0);
  endtask

  // g < 0: no grant expected. For reads, d is the data the response must carry
  // and push selects whether a response is expected at all.
  task automatic expect_grant(input int g, input bit w, input logic [AB-1:0] a,
                              input logic [DB-1:0] d, input bit push);
    logic [NR-1:0] rdy;
    rsp_t e;
    @(negedge clk);
    rdy = '0;
    if (g >= 0) rdy[g] = 1'b1;
    check("req_ready", bus.req_ready, rdy);
    check("sram_wen",  sram_wen, (g >= 0) && w);
    check("sram_ren",  sram_ren, (g >= 0) && !w);
    check("sram_addr", sram_addr, (g >= 0) ? a : '0);
    if (g < 0 || w) check("sram_wdata", sram_wdata, (g >= 0) ? d : '0);
    if (g >= 0 && !w && push) begin
      e.id = g; e.data = d; e.cyc = cyc_cnt + 2;
      exp_q.push_back(e);
    end
  endtask

  // Response monitor.
  always @(negedge clk) begin
    if (bus.rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", bus.rsp_valid, '0);
      end else begin
        rsp_t e;
        logic [NR-1:0] oh;
        e  = exp_q.pop_front();
        oh = '0;
        oh[e.id] = 1'b1;
        check("rsp_valid", bus.rsp_valid, oh);
        check("rsp_id",    bus.rsp_id, e.id[IB-1:0]);
        check("rsp_rdata", bus.rsp_rdata, e.data);
        check("rsp_cycle", cyc_cnt, e.cyc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    clr_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid, '0);
    check("rst_rsp_id",    bus.rsp_id, '0);
    check("rst_rsp_rdata", bus.rsp_rdata, '0);
    check("rst_busy",      busy, 1'b0);
    tick(); rst = 1'b0;
    expect_grant(-1, 0, 0, 0, 0);
    check("idle_busy", busy, 1'b0);

    // Requester 1 write then read of addr 5 (rr_ptr 0 -> 2).
    tick(); set_req(1, 1, 1, 9'd5, pat(8'hA5));
    expect_grant(1, 1, 9'd5, pat(8'hA5), 0);
    tick(); set_req(1, 1, 0, 9'd5, '0);
    expect_grant(1, 0, 9'd5, pat(8'hA5), 1);
    tick(); clr_all();
    expect_grant(-1, 0, 0, 0, 0);
    check("busy_s0", busy, 1'b1);
    tick(); @(negedge clk); check("busy_s1", busy, 1'b1);
    tick(); @(negedge clk); check("busy_clear", busy, 1'b0);

    // Write addr 7 then read it next cycle (rr_ptr 2 -> 3 -> 3).
    tick(); set_req(2, 1, 1, 9'd7, pat(8'h5C));
    expect_grant(2, 1, 9'd7, pat(8'h5C), 0);
    tick(); set_req(2, 1, 0, 9'd7, '0);
    expect_grant(2, 0, 9'd7, pat(8'h5C), 1);
    // Only requester 3 with rr_ptr 3, then pointer wraps to 0.
    tick(); clr_all(); set_req(3, 1, 0, 9'd7, '0);
    expect_grant(3, 0, 9'd7, pat(8'h5C), 1);
    tick(); set_req(0, 1, 0, 9'd5, '0);
    expect_grant(0, 0, 9'd5, pat(8'hA5), 1);
    tick(); set_req(0, 0, 0, '0, '0);
    expect_grant(3, 0, 9'd7, pat(8'h5C), 1);
    tick(); clr_all();
    repeat (3) tick();
    @(negedge clk); check("busy_drain1", busy, 1'b0);

    // All four write addrs 10..13 held together: one grant each, in order.
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) for (int i = 0; i < NR; i++) set_req(i, 1, 1, 9'(10 + i), pat(8'(8'h10 + i)));
      expect_grant(k, 1, 9'(10 + k), pat(8'(8'h10 + k)), 0);
    end
    // All four read held for 8 cycles: 0,1,2,3,0,1,2,3, back-to-back returns.
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) for (int i = 0; i < NR; i++) set_req(i, 1, 0, 9'(10 + i), '0);
      expect_grant(k % 4, 0, 9'(10 + k % 4), pat(8'(8'h10 + k % 4)), 1);
    end
    tick(); clr_all();
    repeat (3) tick();

    // Two reads in flight, then reset: nothing delivered, pointer back to 0.
    tick(); set_req(1, 1, 0, 9'd5, '0);
    expect_grant(1, 0, 9'd5, pat(8'hA5), 0);
    tick(); set_req(1, 0, 0, '0, '0); set_req(2, 1, 0, 9'd7, '0);
    expect_grant(2, 0, 9'd7, pat(8'h5C), 0);
    tick(); clr_all(); rst = 1'b1;
    @(negedge clk);
    check("midrst_rsp_valid", bus.rsp_valid, '0);
    check("midrst_rsp_rdata", bus.rsp_rdata, '0);
    check("midrst_busy",      busy, 1'b0);
    tick(); rst = 1'b0;
    @(negedge clk);
    check("postrst_rsp_valid", bus.rsp_valid, '0);
    check("postrst_busy",      busy, 1'b0);
    tick(); set_req(1, 1, 0, 9'd5, '0); set_req(3, 1, 0, 9'd7, '0);
    expect_grant(1, 0, 9'd5, pat(8'hA5), 1);
    tick(); set_req(1, 0, 0, '0, '0);
    expect_grant(3, 0, 9'd7, pat(8'h5C), 1);
    tick(); clr_all();
    repeat (3) tick();

    // Requesters 0 and 2 held valid.
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) begin
        set_req(0, 1, 0, 9'd5, '0);
        set_req(2, 1, 0, 9'd7, '0);
      end
`ifdef SRAM_ARB_PRIO0_EN
      expect_grant(0, 0, 9'd5, pat(8'hA5), 1);
`else
      if (k % 2 == 0) expect_grant(0, 0, 9'd5, pat(8'hA5), 1);
      else            expect_grant(2, 0, 9'd7, pat(8'h5C), 1);
`endif
    end
    tick(); clr_all();
    repeat (4) tick();
    @(negedge clk);
    check("rsp_missing", exp_q.size(), 0);
    check("final_busy", busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Hard bound in case the clocked flow ever stalls.
  initial begin
    #50000;
    n_err++;
    $display("FAIL timeout actual=running required=finished");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "timeout");
  end
endmodule
